// File: rtl/calc1_unit.sv
// Four-port 32-bit calculator: add, sub, shl, shr.
// Each port runs its own two-cycle request / one-cycle response pipeline.
module calc1_port_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:3]  cmd,
    input  logic [0:31] data,
    output logic [0:1]  resp,
    output logic [0:31] result
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY1,
        BUSY2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic [0:3]  cmd_q;
    logic [0:31] op1_q;
    logic [0:31] op2_q;
    logic [0:32] sum;
    logic [0:1]  resp_d;
    logic [0:31] res_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response cycle doubles as an idle cycle for accepting the next cmd
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd != 4'd0) begin
                    accept  = 1'b1;
                    state_d = BUSY1;
                end
            end
            BUSY1: state_d = BUSY2;
            BUSY2: begin
                if (cmd != 4'd0) begin
                    accept  = 1'b1;
                    state_d = BUSY1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum = {1'b0, op1_q} + {1'b0, op2_q};

    always_comb begin
        resp_d = 2'd2;
        res_d  = 32'd0;
        unique case (cmd_q)
            4'd1: begin
                if (!sum[0]) begin
                    resp_d = 2'd1;
                    res_d  = sum[1:32];
                end
            end
            4'd2: begin
                if (op2_q <= op1_q) begin
                    resp_d = 2'd1;
                    res_d  = op1_q - op2_q;
                end
            end
            4'd5: begin
                resp_d = 2'd1;
                res_d  = op1_q << op2_q[27:31];
            end
            4'd6: begin
                resp_d = 2'd1;
                res_d  = op1_q >> op2_q[27:31];
            end
            default: begin
                resp_d = 2'd2;
                res_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= 4'd0;
            op1_q  <= 32'd0;
            op2_q  <= 32'd0;
            resp   <= 2'd0;
            result <= 32'd0;
        end else begin
            if (accept) begin
                cmd_q <= cmd;
                op1_q <= data;
            end
            if (state_q == BUSY1) begin
                op2_q <= data;
            end
            if (state_q == BUSY2) begin
                resp   <= resp_d;
                result <= res_d;
            end else begin
                resp   <= 2'd0;
                result <= 32'd0;
            end
        end
    end

endmodule

module calc1_unit (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data4
);

    calc1_port_stage u_port1 (
        .clk    (c_clk),
        .rst_n  (reset),
        .cmd    (req1_cmd_in),
        .data   (req1_data_in),
        .resp   (out_resp1),
        .result (out_data1)
    );

    calc1_port_stage u_port2 (
        .clk    (c_clk),
        .rst_n  (reset),
        .cmd    (req2_cmd_in),
        .data   (req2_data_in),
        .resp   (out_resp2),
        .result (out_data2)
    );

    calc1_port_stage u_port3 (
        .clk    (c_clk),
        .rst_n  (reset),
        .cmd    (req3_cmd_in),
        .data   (req3_data_in),
        .resp   (out_resp3),
        .result (out_data3)
    );

    calc1_port_stage u_port4 (
        .clk    (c_clk),
        .rst_n  (reset),
        .cmd    (req4_cmd_in),
        .data   (req4_data_in),
        .resp   (out_resp4),
        .result (out_data4)
    );

endmodule

// File: tb/tb_calc1_unit.sv
// Directed-vector bench for calc1_unit.
// Vectors run on every port, then multi-cycle corner sequences.
module tb_calc1_unit;

    logic        c_clk;
    logic        reset;
    logic [0:3]  cmd [4];
    logic [0:31] dat [4];
    logic [0:1]  resp [4];
    logic [0:31] rdat [4];

    int compared;
    int mismatched;

    typedef struct {
        logic [0:3]  cmd;
        logic [0:31] op1;
        logic [0:31] op2;
        logic [0:1]  eresp;
        logic [0:31] edata;
    } vec_t;

    vec_t vecs [16];

    calc1_unit dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd[0]),
        .req1_data_in (dat[0]),
        .req2_cmd_in  (cmd[1]),
        .req2_data_in (dat[1]),
        .req3_cmd_in  (cmd[2]),
        .req3_data_in (dat[2]),
        .req4_cmd_in  (cmd[3]),
        .req4_data_in (dat[3]),
        .out_resp1    (resp[0]),
        .out_data1    (rdat[0]),
        .out_resp2    (resp[1]),
        .out_data2    (rdat[1]),
        .out_resp3    (resp[2]),
        .out_data3    (rdat[2]),
        .out_resp4    (resp[3]),
        .out_data4    (rdat[3])
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic chk(input string nm, input int p,
                       input logic [0:1] er, input logic [0:31] ed);
        compared++;
        if (resp[p] !== er || rdat[p] !== ed) begin
            mismatched++;
            $display("FAIL %s port%0d: got resp=%0d data=%h, want resp=%0d data=%h",
                     nm, p + 1, resp[p], rdat[p], er, ed);
        end
    endtask

    task automatic chk_idle(input string nm);
        for (int p = 0; p < 4; p++) chk(nm, p, 2'd0, 32'd0);
    endtask

    task automatic txn(input int p, input vec_t v, input string nm);
        @(negedge c_clk);
        cmd[p] = v.cmd;
        dat[p] = v.op1;
        @(negedge c_clk);
        cmd[p] = 4'd0;
        dat[p] = v.op2;
        @(negedge c_clk);
        dat[p] = 32'd0;
        @(posedge c_clk);
        #1 chk(nm, p, v.eresp, v.edata);
        @(posedge c_clk);
        #1 chk({nm, "_clr"}, p, 2'd0, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            dat[p] = 32'd0;
        end

        vecs[0]  = '{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
        vecs[1]  = '{4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE};
        vecs[2]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[3]  = '{4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
        vecs[4]  = '{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000};
        vecs[5]  = '{4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E};
        vecs[6]  = '{4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0000_0000};
        vecs[7]  = '{4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[8]  = '{4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[9]  = '{4'd5, 32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010};
        vecs[10] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        vecs[11] = '{4'd5, 32'hF000_000F, 32'h0000_0004, 2'd1, 32'h0000_00F0};
        vecs[12] = '{4'd6, 32'h8000_0000, 32'hFFFF_FFE1, 2'd1, 32'h4000_0000};
        vecs[13] = '{4'd5, 32'hDEAD_BEEF, 32'h0000_0020, 2'd1, 32'hDEAD_BEEF};
        vecs[14] = '{4'd15, 32'h0000_0005, 32'h0000_0005, 2'd2, 32'h0000_0000};
        vecs[15] = '{4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF};

        reset = 1'b0;
        repeat (4) @(posedge c_clk);
        #1 chk_idle("reset");
        @(negedge c_clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge c_clk);
            #1 chk_idle("idle");
        end

        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                txn(p, vecs[i], $sformatf("vec%0d", i));

        // All four ports in parallel, add x + 0
        for (int k = 0; k < 15; k++) begin
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                cmd[p] = 4'd1;
                dat[p] = 32'd1 << k;
            end
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                cmd[p] = 4'd0;
                dat[p] = 32'd0;
            end
            @(posedge c_clk);
            #1 chk_idle("par_e1");
            @(posedge c_clk);
            #1 for (int p = 0; p < 4; p++) chk("par", p, 2'd1, 32'd1 << k);
        end
        @(posedge c_clk);
        #1 chk_idle("par_clr");

        // Distinct per-port operations in the same cycle
        @(negedge c_clk);
        cmd[0] = 4'd1; dat[0] = 32'd10;
        cmd[1] = 4'd2; dat[1] = 32'd10;
        cmd[2] = 4'd5; dat[2] = 32'd3;
        cmd[3] = 4'd7; dat[3] = 32'd9;
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            dat[p] = 32'd2;
        end
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) dat[p] = 32'd0;
        @(posedge c_clk);
        #1;
        chk("mix_add", 0, 2'd1, 32'd12);
        chk("mix_sub", 1, 2'd1, 32'd8);
        chk("mix_shl", 2, 2'd1, 32'd12);
        chk("mix_inv", 3, 2'd2, 32'd0);

        // Back-to-back: new cmd sampled on the response edge
        @(negedge c_clk);
        cmd[0] = 4'd1; dat[0] = 32'd3;
        @(negedge c_clk);
        cmd[0] = 4'd0; dat[0] = 32'd4;
        @(negedge c_clk);
        cmd[0] = 4'd1; dat[0] = 32'd10;
        @(posedge c_clk);
        #1 chk("b2b_first", 0, 2'd1, 32'd7);
        @(negedge c_clk);
        cmd[0] = 4'd0; dat[0] = 32'd5;
        @(posedge c_clk);
        #1 chk("b2b_gap", 0, 2'd0, 32'd0);
        @(negedge c_clk);
        dat[0] = 32'd0;
        @(posedge c_clk);
        #1 chk("b2b_second", 0, 2'd1, 32'd15);

        // cmd during the operand-2 cycle is ignored
        @(negedge c_clk);
        cmd[1] = 4'd1; dat[1] = 32'd2;
        @(negedge c_clk);
        cmd[1] = 4'd2; dat[1] = 32'd3;
        @(negedge c_clk);
        cmd[1] = 4'd0; dat[1] = 32'd0;
        @(posedge c_clk);
        #1 chk("busy1_cmd", 1, 2'd1, 32'd5);
        repeat (4) begin
            @(posedge c_clk);
            #1 chk("busy1_ign", 1, 2'd0, 32'd0);
        end

        // Reset while a request is in flight
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd1;
            dat[p] = 32'd5;
        end
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            dat[p] = 32'd6;
        end
        @(negedge c_clk);
        reset = 1'b0;
        #1 chk_idle("rst_mid");
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) dat[p] = 32'd0;
        reset = 1'b1;
        repeat (4) begin
            @(posedge c_clk);
            #1 chk_idle("rst_drop");
        end
        txn(0, vecs[5], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
